// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard/run controller.
//   core_state_t : run-control FSM encoding (LOAD, RUN, DRAIN, HALTED)
//   FWD_*        : EX operand select encodings
//   tracker_t    : per-stage destination/control metadata record
package pipe_ctrl_pkg;

   localparam int unsigned ADDR_W = 5;

   typedef enum logic [1:0] {
      ST_LOAD   = 2'b00,
      ST_RUN    = 2'b01,
      ST_DRAIN  = 2'b10,
      ST_HALTED = 2'b11
   } core_state_t;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   typedef struct packed {
      logic              valid;
      logic [ADDR_W-1:0] rs1;
      logic [ADDR_W-1:0] rs2;
      logic              use1;
      logic              use2;
      logic [ADDR_W-1:0] rd;
      logic              reg_write;
      logic              mem_read;
   } tracker_t;

   localparam tracker_t TRK_EMPTY = '0;

   // True when stage entry t produces the value that operand rs needs.
   function automatic logic produces(input logic              valid,
                                     input logic              reg_write,
                                     input logic [ADDR_W-1:0] rd,
                                     input logic [ADDR_W-1:0] rs,
                                     input logic              use_rs);
      return valid & reg_write & (rd != '0) & (rd == rs) & use_rs;
   endfunction

endpackage

// File: rtl/fwd_select.sv
// fwd_select: combinational forwarding select for one EX source operand.
//   rs, use_rs : source register index and whether it is actually read
//   ex_mem     : EX/MEM tracker entry (highest priority)
//   mem_wb     : MEM/WB tracker entry
//   sel_c      : 2-bit operand select (FWD_RF / FWD_EXMEM / FWD_MEMWB)
module fwd_select
   import pipe_ctrl_pkg::*;
(
   input  logic [ADDR_W-1:0] rs,
   input  logic              use_rs,
   input  tracker_t          ex_mem,
   input  tracker_t          mem_wb,
   output logic [1:0]        sel_c
);

   // Youngest producer wins.
   always_comb begin
      sel_c = FWD_RF;
      if (produces(ex_mem.valid, ex_mem.reg_write, ex_mem.rd, rs, use_rs)) begin
         sel_c = FWD_EXMEM;
      end else if (produces(mem_wb.valid, mem_wb.reg_write, mem_wb.rd, rs, use_rs)) begin
         sel_c = FWD_MEMWB;
      end
   end

   // Source-side and load fields of the older entries play no part in forwarding.
   logic unused;
   assign unused = ^{ex_mem.rs1, ex_mem.rs2, ex_mem.use1, ex_mem.use2, ex_mem.mem_read,
                     mem_wb.rs1, mem_wb.rs2, mem_wb.use1, mem_wb.use2, mem_wb.mem_read};

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: pipeline control for a 5-stage core.
// Tracks ID/EX, EX/MEM, MEM/WB metadata and produces forwarding selects,
// load-use stalls, taken-branch flushes, run-control state and perf counters.
//   clk, rst_n                 : clock, async active-low reset
//   load_mode, start           : run-control requests
//   id_*                       : decoded ID-stage instruction
//   branch_taken               : branch resolved taken in EX/MEM
//   fwd_a, fwd_b               : EX operand selects
//   pc_en, if_id_en            : PC / IF-ID load enables
//   if_id_flush, id_ex_flush,
//   ex_mem_flush               : bubble insertion per pipeline register
//   core_state                 : 00 LOAD, 01 RUN, 10 DRAIN, 11 HALTED
//   stall_cnt, flush_cnt       : saturating performance counters
module pipeline_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_W   = ADDR_W,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned DRAIN_CYCLES = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_mode,
   input  logic                  start,
   input  logic                  id_valid,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic                  id_uses_rs1,
   input  logic                  id_uses_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_halt,
   input  logic                  branch_taken,
   output logic [1:0]            fwd_a,
   output logic [1:0]            fwd_b,
   output logic                  pc_en,
   output logic                  if_id_en,
   output logic                  if_id_flush,
   output logic                  id_ex_flush,
   output logic                  ex_mem_flush,
   output logic [1:0]            core_state,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam int unsigned DRN_W   = (DRAIN_CYCLES < 1) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   core_state_t      state;
   logic [DRN_W-1:0] drain_cnt;
   tracker_t         id_ex;
   tracker_t         ex_mem;
   tracker_t         mem_wb;
   tracker_t         id_entry;

   logic in_run;
   logic in_drain;
   logic load_use;
   logic branch_act;
   logic adv;
   logic stall_inc;
   logic all_empty;

   assign in_run   = (state == ST_RUN);
   assign in_drain = (state == ST_DRAIN);

   // Instruction in ID needs a value still being loaded by the instruction in EX.
   assign load_use = in_run & id_valid & id_ex.valid & id_ex.mem_read & (id_ex.rd != '0) &
                     ((id_uses_rs1 & (ADDR_W'(id_rs1) == id_ex.rd)) |
                      (id_uses_rs2 & (ADDR_W'(id_rs2) == id_ex.rd)));

   assign branch_act = branch_taken & (in_run | in_drain);
   assign adv        = in_run & id_valid & ~load_use & ~branch_taken;
   // A taken branch squashes the load, so the stall never happens.
   assign stall_inc  = load_use & ~branch_taken;
   assign all_empty  = ~id_ex.valid & ~ex_mem.valid & ~mem_wb.valid;

   always_comb begin
      id_entry           = TRK_EMPTY;
      id_entry.valid     = 1'b1;
      id_entry.rs1       = ADDR_W'(id_rs1);
      id_entry.rs2       = ADDR_W'(id_rs2);
      id_entry.use1      = id_uses_rs1;
      id_entry.use2      = id_uses_rs2;
      id_entry.rd        = ADDR_W'(id_rd);
      id_entry.reg_write = id_reg_write;
      id_entry.mem_read  = id_mem_read;
   end

   fwd_select u_fwd_a (
      .rs     (id_ex.rs1),
      .use_rs (id_ex.use1),
      .ex_mem (ex_mem),
      .mem_wb (mem_wb),
      .sel_c  (fwd_a)
   );

   fwd_select u_fwd_b (
      .rs     (id_ex.rs2),
      .use_rs (id_ex.use2),
      .ex_mem (ex_mem),
      .mem_wb (mem_wb),
      .sel_c  (fwd_b)
   );

   // Trackers, counters and run-control state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_LOAD;
         drain_cnt <= '0;
         id_ex     <= TRK_EMPTY;
         ex_mem    <= TRK_EMPTY;
         mem_wb    <= TRK_EMPTY;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         id_ex  <= adv ? id_entry : TRK_EMPTY;
         ex_mem <= branch_act ? TRK_EMPTY : id_ex;
         mem_wb <= ex_mem;

         if (stall_inc && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (branch_act && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end

         case (state)
            ST_LOAD: begin
               if (start) begin
                  state     <= ST_RUN;
                  stall_cnt <= '0;
                  flush_cnt <= '0;
               end
            end
            ST_RUN: begin
               if (id_halt && adv) begin
                  state     <= ST_DRAIN;
                  drain_cnt <= DRN_W'(DRAIN_CYCLES);
               end
            end
            ST_DRAIN: begin
               // A taken branch behind the halt means the halt was on the wrong path.
               if (branch_taken) begin
                  state     <= ST_RUN;
                  drain_cnt <= '0;
               end else if ((drain_cnt == '0) && all_empty) begin
                  state <= ST_HALTED;
               end else if (drain_cnt != '0) begin
                  drain_cnt <= drain_cnt - DRN_W'(1);
               end
            end
            ST_HALTED: begin
               if (load_mode) begin
                  state <= ST_LOAD;
               end else if (start) begin
                  state <= ST_RUN;
               end
            end
            default: state <= ST_LOAD;
         endcase
      end
   end

   // Enables and flushes; LOAD/HALTED freeze fetch and bubble everything.
   always_comb begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      case (state)
         ST_RUN: begin
            pc_en        = ~load_use;
            if_id_en     = ~load_use;
            if_id_flush  = 1'b0;
            id_ex_flush  = load_use;
            ex_mem_flush = 1'b0;
         end
         ST_DRAIN: begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
         end
         default: ;
      endcase
      if (branch_act) begin
         pc_en        = 1'b1;
         if_id_en     = 1'b1;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         ex_mem_flush = 1'b1;
      end
   end

   assign core_state = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned AW = 5;
   localparam int unsigned CW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          load_mode;
   logic          start;
   logic          id_valid;
   logic [AW-1:0] id_rs1;
   logic [AW-1:0] id_rs2;
   logic          id_uses_rs1;
   logic          id_uses_rs2;
   logic [AW-1:0] id_rd;
   logic          id_reg_write;
   logic          id_mem_read;
   logic          id_halt;
   logic          branch_taken;
   logic [1:0]    fwd_a;
   logic [1:0]    fwd_b;
   logic          pc_en;
   logic          if_id_en;
   logic          if_id_flush;
   logic          id_ex_flush;
   logic          ex_mem_flush;
   logic [1:0]    core_state;
   logic [CW-1:0] stall_cnt;
   logic [CW-1:0] flush_cnt;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(
      .REG_ADDR_W   (AW),
      .CNT_W        (CW),
      .DRAIN_CYCLES (3)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_mode    (load_mode),
      .start        (start),
      .id_valid     (id_valid),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_uses_rs1  (id_uses_rs1),
      .id_uses_rs2  (id_uses_rs2),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .id_halt      (id_halt),
      .branch_taken (branch_taken),
      .fwd_a        (fwd_a),
      .fwd_b        (fwd_b),
      .pc_en        (pc_en),
      .if_id_en     (if_id_en),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .ex_mem_flush (ex_mem_flush),
      .core_state   (core_state),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   // Flush/enable bundle checked as one vector {pc_en, if_id_flush, id_ex_flush, ex_mem_flush}.
   task automatic check_ctl(input string tag, input logic [3:0] exp);
      check(tag, 32'({pc_en, if_id_flush, id_ex_flush, ex_mem_flush}), 32'(exp));
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
      id_rd = '0; id_reg_write = 1'b0; id_mem_read = 1'b0; id_halt = 1'b0;
   endtask

   task automatic instr(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic u1, input logic u2, input logic [AW-1:0] rd,
                        input logic rw, input logic mr, input logic hlt);
      id_valid = 1'b1; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
      id_rd = rd; id_reg_write = rw; id_mem_read = mr; id_halt = hlt;
   endtask

   initial begin
      rst_n = 1'b0; load_mode = 1'b0; start = 1'b0; branch_taken = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      next_cycle(); next_cycle();

      // Out of reset, no start yet
      #1;
      check("rst_state", 32'(core_state), 32'h0);
      check_ctl("rst_ctl", 4'b0111);
      check("rst_if_id_en", 32'(if_id_en), 32'h0);
      check("rst_fwd", 32'({fwd_a, fwd_b}), 32'h0);
      check("rst_cnts", 32'({stall_cnt, flush_cnt}), 32'h0);

      start = 1'b1; next_cycle(); start = 1'b0;
      #1;
      check("run_state", 32'(core_state), 32'h1);
      check_ctl("run_idle_ctl", 4'b1000);

      // add x3,x1,x2 ; sub x4,x3,x1 -> EX/MEM forward on A
      instr(1, 2, 1, 1, 3, 1, 0, 0); next_cycle();
      instr(3, 1, 1, 1, 4, 1, 0, 0); #1;
      check_ctl("no_hazard_ctl", 4'b1000);
      next_cycle(); idle(); #1;
      check("exmem_fwd_a", 32'(fwd_a), 32'h2);
      check("exmem_fwd_b", 32'(fwd_b), 32'h0);
      repeat (3) next_cycle();

      // add ; nop ; sub -> MEM/WB forward on A
      instr(1, 2, 1, 1, 3, 1, 0, 0); next_cycle();
      idle(); next_cycle();
      instr(3, 1, 1, 1, 4, 1, 0, 0); next_cycle();
      idle(); #1;
      check("memwb_fwd_a", 32'(fwd_a), 32'h1);
      check("memwb_fwd_b", 32'(fwd_b), 32'h0);
      repeat (3) next_cycle();

      // Two producers of x7 in flight: EX/MEM wins on both operands
      instr(1, 2, 1, 1, 7, 1, 0, 0); next_cycle();
      instr(1, 2, 1, 1, 7, 1, 0, 0); next_cycle();
      instr(7, 7, 1, 1, 8, 1, 0, 0); next_cycle();
      idle(); #1;
      check("prio_fwd", 32'({fwd_a, fwd_b}), 32'hA);
      repeat (3) next_cycle();

      // lw x5,0(x0) ; add x6,x5,x5 -> one stall cycle, then MEM/WB forward
      instr(0, 0, 1, 0, 5, 1, 1, 0); next_cycle();
      instr(5, 5, 1, 1, 6, 1, 0, 0); #1;
      check_ctl("lu_ctl", 4'b0010);
      check("lu_if_id_en", 32'(if_id_en), 32'h0);
      next_cycle(); #1;
      check_ctl("lu_release_ctl", 4'b1000);
      check("lu_stall_cnt", 32'(stall_cnt), 32'h1);
      next_cycle(); idle(); #1;
      check("lu_fwd", 32'({fwd_a, fwd_b}), 32'h5);
      repeat (3) next_cycle();

      // Write x0 then read x0 -> no forwarding
      instr(1, 2, 1, 1, 0, 1, 0, 0); next_cycle();
      instr(0, 0, 1, 1, 4, 1, 0, 0); next_cycle();
      idle(); #1;
      check("x0_fwd", 32'({fwd_a, fwd_b}), 32'h0);
      repeat (3) next_cycle();

      // lw x0 then read x0 -> no stall, no forwarding
      instr(0, 0, 1, 0, 0, 1, 1, 0); next_cycle();
      instr(0, 0, 1, 1, 6, 1, 0, 0); #1;
      check_ctl("x0_lu_ctl", 4'b1000);
      next_cycle(); idle(); #1;
      check("x0_lu_fwd", 32'({fwd_a, fwd_b}), 32'h0);
      check("x0_lu_stall_cnt", 32'(stall_cnt), 32'h1);
      repeat (3) next_cycle();

      // Taken branch together with a load-use condition
      instr(0, 0, 1, 0, 5, 1, 1, 0); next_cycle();
      instr(5, 5, 1, 1, 6, 1, 0, 0); branch_taken = 1'b1; #1;
      check_ctl("br_lu_ctl", 4'b1111);
      next_cycle(); branch_taken = 1'b0; idle(); #1;
      check("br_stall_cnt", 32'(stall_cnt), 32'h1);
      check("br_flush_cnt", 32'(flush_cnt), 32'h1);
      check("br_state", 32'(core_state), 32'h1);
      repeat (3) next_cycle();

      // Halt: DRAIN while the pipe empties, then HALTED
      instr(0, 0, 0, 0, 0, 0, 0, 1); #1;
      check_ctl("halt_accept_ctl", 4'b1000);
      next_cycle(); idle();
      for (int i = 0; i < 4; i++) begin
         #1;
         check($sformatf("drain_state_%0d", i), 32'(core_state), 32'h2);
         if (i == 0) check_ctl("drain_ctl", 4'b0100);
         next_cycle();
      end
      #1;
      check("halted_state", 32'(core_state), 32'h3);
      check_ctl("halted_ctl", 4'b0111);

      // load_mode beats start in HALTED; LOAD keeps counters until start
      load_mode = 1'b1; start = 1'b1; next_cycle(); load_mode = 1'b0; start = 1'b0; #1;
      check("load_state", 32'(core_state), 32'h0);
      check("load_stall_kept", 32'(stall_cnt), 32'h1);
      start = 1'b1; next_cycle(); start = 1'b0; #1;
      check("restart_state", 32'(core_state), 32'h1);
      check("restart_cnts", 32'({stall_cnt, flush_cnt}), 32'h0);

      // Wrong-path halt: branch in first DRAIN cycle returns to RUN
      instr(0, 0, 0, 0, 0, 0, 0, 1); next_cycle();
      idle(); branch_taken = 1'b1; #1;
      check("wp_drain_state", 32'(core_state), 32'h2);
      check_ctl("wp_drain_ctl", 4'b1111);
      next_cycle(); branch_taken = 1'b0; #1;
      check("wp_run_state", 32'(core_state), 32'h1);
      check_ctl("wp_run_ctl", 4'b1000);
      check("wp_flush_cnt", 32'(flush_cnt), 32'h1);

      // HALTED -> start resumes without clearing counters
      instr(0, 0, 0, 0, 0, 0, 0, 1); next_cycle();
      idle(); repeat (4) next_cycle(); #1;
      check("halt2_state", 32'(core_state), 32'h3);
      start = 1'b1; next_cycle(); start = 1'b0; #1;
      check("resume_state", 32'(core_state), 32'h1);
      check("resume_flush_cnt", 32'(flush_cnt), 32'h1);

      // flush_cnt saturates at 2^CW-1
      branch_taken = 1'b1; repeat (20) next_cycle(); branch_taken = 1'b0; #1;
      check("sat_flush_cnt", 32'(flush_cnt), 32'hF);
      check("sat_stall_cnt", 32'(stall_cnt), 32'h0);

      // Asynchronous reset mid-run
      instr(1, 2, 1, 1, 3, 1, 0, 0); #1;
      rst_n = 1'b0; #1;
      check("async_rst_state", 32'(core_state), 32'h0);
      check_ctl("async_rst_ctl", 4'b0111);
      check("async_rst_cnt", 32'(flush_cnt), 32'h0);
      #2 rst_n = 1'b1; idle();
      next_cycle(); next_cycle(); #1;
      check("post_rst_state", 32'(core_state), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
